// File: rtl/escape_sequence_decoder_if.sv
// ============================================================================
// Module      : escape_sequence_decoder_if (+ escape_sequence_decoder_pkg)
// Description : Command types, parameter record and byte/command interface
//               for the escape sequence decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package escape_sequence_decoder_pkg;

    typedef enum logic [3:0] {
        INPUT = 4'd0,
        HTS   = 4'd1,
        CUU   = 4'd2,
        CUD   = 4'd3,
        CUF   = 4'd4,
        CUB   = 4'd5,
        CUP   = 4'd6,
        ED    = 4'd7,
        EL    = 4'd8,
        TBC   = 4'd9
    } CommandsType;

    typedef struct packed {
        logic [7:0] Pn1;
        logic [7:0] Pn2;
        logic [7:0] Pchar;
    } Param_t;

endpackage

interface escape_sequence_decoder_if;
    import escape_sequence_decoder_pkg::*;

    logic        charValid;
    logic [7:0]  charData;
    logic        charReady;
    logic        downstreamBusy;
    logic        commandReady;
    CommandsType commandType;
    Param_t      paramt;

    // Host byte source and downstream consumers share the master side.
    modport master (
        output charValid, charData, downstreamBusy,
        input  charReady, commandReady, commandType, paramt
    );

    modport slave (
        input  charValid, charData, downstreamBusy,
        output charReady, commandReady, commandType, paramt
    );

endinterface

`default_nettype wire

// File: rtl/escape_sequence_decoder.sv
// ============================================================================
// Module      : escape_sequence_decoder
// Description : Turns the raw host byte stream into plain-character, ESC and
//               CSI commands with up to two saturating decimal parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module escape_sequence_decoder
    import escape_sequence_decoder_pkg::*;
#(
    parameter int ESC_TIMEOUT = 50000,
    parameter int PN_MAX      = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    escape_sequence_decoder_if.slave    dec
);

    localparam logic [1:0] S_GROUND = 2'd0;
    localparam logic [1:0] S_ESC    = 2'd1;
    localparam logic [1:0] S_CSI    = 2'd2;

    localparam int                 c_TO_W     = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(ESC_TIMEOUT - 1);
    localparam logic [11:0]        c_PN_MAX   = 12'(PN_MAX);
    localparam logic [7:0]         c_PN_MAX_8 = 8'(PN_MAX);

    localparam logic [7:0] c_ESC  = 8'h1B;
    localparam logic [7:0] c_LBR  = 8'h5B;
    localparam logic [7:0] c_SEMI = 8'h3B;
    localparam logic [7:0] c_CAN  = 8'h18;
    localparam logic [7:0] c_SUB  = 8'h1A;
    localparam logic [7:0] c_H    = 8'h48;

    logic [1:0]        r_state;
    logic [7:0]        r_pn1;
    logic [7:0]        r_pn2;
    logic [1:0]        r_idx;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_cmd_ready;
    CommandsType       r_cmd_type;
    Param_t            r_param;

    logic              w_accept;
    logic [7:0]        w_byte;
    logic              w_is_digit;
    logic              w_is_final;
    logic [7:0]        w_acc_cur;
    logic [11:0]       w_acc_next;
    logic [7:0]        w_acc_sat;
    logic              w_final_hit;
    CommandsType       w_final_cmd;

    assign dec.charReady    = !dec.downstreamBusy;
    assign dec.commandReady = r_cmd_ready;
    assign dec.commandType  = r_cmd_type;
    assign dec.paramt       = r_param;

    assign w_accept   = dec.charValid && !dec.downstreamBusy;
    assign w_byte     = dec.charData;
    assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
    assign w_is_final = (w_byte >= 8'h40) && (w_byte <= 8'h7E);

    // Accumulate at 12 bits so 255*10+9 cannot wrap before saturation.
    assign w_acc_cur  = (r_idx == 2'd0) ? r_pn1 : r_pn2;
    assign w_acc_next = {4'd0, w_acc_cur} * 12'd10 + {8'd0, w_byte[3:0]};
    assign w_acc_sat  = (w_acc_next > c_PN_MAX) ? c_PN_MAX_8 : w_acc_next[7:0];

    always_comb begin
        w_final_hit = 1'b1;
        w_final_cmd = INPUT;
        case (w_byte)
            8'h41:        w_final_cmd = CUU;
            8'h42:        w_final_cmd = CUD;
            8'h43:        w_final_cmd = CUF;
            8'h44:        w_final_cmd = CUB;
            8'h48, 8'h66: w_final_cmd = CUP;
            8'h4A:        w_final_cmd = ED;
            8'h4B:        w_final_cmd = EL;
            8'h67:        w_final_cmd = TBC;
            default:      w_final_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_GROUND;
            r_pn1       <= 8'd0;
            r_pn2       <= 8'd0;
            r_idx       <= 2'd0;
            r_to_cnt    <= '0;
            r_cmd_ready <= 1'b0;
            r_cmd_type  <= INPUT;
            r_param     <= '0;
        end else begin
            r_cmd_ready <= 1'b0;
            if (w_accept) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_GROUND: begin
                        if (w_byte == c_ESC) begin
                            r_state <= S_ESC;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_cmd_type  <= INPUT;
                            r_param     <= '{Pn1: 8'd0, Pn2: 8'd0, Pchar: w_byte};
                        end
                    end
                    S_ESC: begin
                        if (w_byte == c_LBR) begin
                            r_state <= S_CSI;
                            r_pn1   <= 8'd0;
                            r_pn2   <= 8'd0;
                            r_idx   <= 2'd0;
                        end else if (w_byte == c_H) begin
                            r_state     <= S_GROUND;
                            r_cmd_ready <= 1'b1;
                            r_cmd_type  <= HTS;
                            r_param     <= '{Pn1: 8'd0, Pn2: 8'd0, Pchar: c_H};
                        end else if (w_byte != c_ESC) begin
                            r_state <= S_GROUND;
                        end
                    end
                    S_CSI: begin
                        if (w_is_digit) begin
                            // A third parameter is parsed but discarded.
                            if (r_idx == 2'd0) begin
                                r_pn1 <= w_acc_sat;
                            end else if (r_idx == 2'd1) begin
                                r_pn2 <= w_acc_sat;
                            end
                        end else if (w_byte == c_SEMI) begin
                            if (r_idx != 2'd2) begin
                                r_idx <= r_idx + 2'd1;
                            end
                        end else if (w_byte == c_ESC) begin
                            r_state <= S_ESC;
                        end else if ((w_byte == c_CAN) || (w_byte == c_SUB)) begin
                            r_state <= S_GROUND;
                        end else if (w_is_final) begin
                            r_state <= S_GROUND;
                            if (w_final_hit) begin
                                r_cmd_ready <= 1'b1;
                                r_cmd_type  <= w_final_cmd;
                                r_param     <= '{Pn1: r_pn1, Pn2: r_pn2, Pchar: w_byte};
                            end
                        end
                    end
                    default: begin
                        r_state <= S_GROUND;
                    end
                endcase
            end else if (r_state == S_GROUND) begin
                r_to_cnt <= '0;
            end else if (!dec.downstreamBusy) begin
                // A stalled sequence is abandoned silently.
                if (r_to_cnt == c_TO_LAST) begin
                    r_state  <= S_GROUND;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/escape_sequence_decoder.md
Name: escape_sequence_decoder

Overview:
- Upstream stage of the parser chain. Converts the raw host byte stream into decoded commands: commandReady, commandType and paramt.
- The tab-stop unit, the cursor unit and the erase unit all consume these outputs.
- Recognises plain characters, ESC-prefixed commands and CSI sequences with up to two decimal parameters.
- Holds off input while a downstream multi-cycle operation is running, for example a tab-stop search.

Parameters:
- ESC_TIMEOUT, default 50000: idle cycles allowed inside an unfinished ESC or CSI sequence before it is abandoned.
- PN_MAX, default 255: saturation value for each decimal parameter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- charValid  in  1  an input byte is present.
- charData  in  8  the input byte.
- charReady  out  1  the byte is accepted when charValid && charReady. Combinational: charReady = !downstreamBusy.
- downstreamBusy  in  1  a consumer is mid-operation, for example the tab search loop.
- commandReady  out  1  one-cycle pulse; outputs are valid when it is high.
- commandType  out  CommandsType  decoded command.
- paramt  out  Param_t  fields Pn1[7:0], Pn2[7:0], Pchar[7:0].

Behaviour:
- Reset: state S_GROUND, commandReady=0, commandType=INPUT, paramt all fields 0, parameter accumulators 0, parameter index 0, timeout counter 0.
- Latency: a command is registered on the accept edge of its final byte. commandReady is therefore high during the cycle after that byte's accept cycle. At most one command per accepted byte.
- commandReady is forced low every cycle in which no command is emitted.
- commandType and paramt hold their last values between pulses. Fields not used by a command are written 0.

State S_GROUND:
- 0x1B -> S_ESC.
- Any other byte, including 0x09 and other C0 codes -> emit INPUT with Pchar=byte.

State S_ESC:
- 0x5B '[' -> S_CSI. Clear Pn1, Pn2 and the parameter index.
- 0x48 'H' -> emit HTS, go to S_GROUND.
- 0x1B -> stay in S_ESC.
- Any other byte -> S_GROUND, nothing emitted.

State S_CSI:
- Digits 0x30-0x39: acc = acc*10 + digit, computed at 12 bits and saturated to PN_MAX. The digit goes to the parameter selected by the index; index 2 means the digit is discarded.
- 0x3B ';': index = min(index+1, 2).
- Final byte in 0x40-0x7E, then go to S_GROUND:
  - 'A' -> CUU, 'B' -> CUD, 'C' -> CUF, 'D' -> CUB.
  - 'H' or 'f' -> CUP.
  - 'J' -> ED, 'K' -> EL.
  - 'g' -> TBC.
  - Any other final byte -> nothing emitted.
- 0x1B -> S_ESC, partial sequence dropped.
- 0x18 or 0x1A -> S_GROUND, nothing emitted.
- Other bytes are ignored and the state is unchanged.

Parameter rules:
- An omitted parameter is emitted as 0. Default interpretation (for example 0 meaning 1) belongs to the consumer.
- Pchar = final byte for CSI commands and 0x48 for HTS.

Timeout:
- The counter clears on every accepted byte and in S_GROUND.
- Otherwise it increments each cycle. When it reaches ESC_TIMEOUT-1 the state returns to S_GROUND with nothing emitted.
- The counter does not increment while downstreamBusy=1.

Other rules:
- A byte presented while downstreamBusy=1 is not accepted: state and params are unchanged and the byte must be held by the source.
- downstreamBusy rising in the same cycle as a commandReady pulse does not cancel that pulse.
- Reset mid-sequence: return to the reset values on the next edge, with no emit.

Test Plan:
- Bytes 0x41, 0x09 with downstreamBusy=0 -> two pulses on consecutive cycles: INPUT Pchar=0x41, then INPUT Pchar=0x09. Each pulse is one cycle after its byte's accept cycle.
- "ESC [ 1 2 ; 3 4 H" -> single pulse CUP, Pn1=12, Pn2=34, Pchar=0x48. No pulse for the intermediate bytes.
- "ESC [ 9 9 9 ; ; 7 A" -> CUU, Pn1=255 (saturated), Pn2=0, third parameter discarded. Then "ESC [ g" -> TBC, Pn1=0. Then "ESC [ 3 g" -> TBC, Pn1=3.
- "ESC H" while downstreamBusy=1 for 5 cycles -> charReady=0 and no accept for those 5 cycles. After busy drops: HTS pulse, Pchar=0x48.
- "ESC [ 5", then idle for ESC_TIMEOUT cycles, then "C" -> no CUF. INPUT Pchar=0x43 is emitted instead.
- "ESC [ 4 ESC [ 2 K" -> EL, Pn1=2. "ESC [ 6 CAN" -> no pulse. rst asserted after "ESC [" -> a following 0x42 gives INPUT Pchar=0x42.
